// File: rtl/pong_pkg.sv
// Shared constants and types for the pong frame scheduler: grid geometry,
// colour width, cell coordinates and the scheduler state encoding.
package pong_pkg;

  localparam int BLOCKING_FACTOR = 20;
  localparam int HCELLS          = 640 / BLOCKING_FACTOR;
  localparam int VCELLS          = 480 / BLOCKING_FACTOR;
  localparam int COLOR_W         = 12;
  localparam int CELL_W          = 5;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_DRAW  = 2'd1,
    ST_READY = 2'd2
  } sched_state_t;

  function automatic logic in_grid(input cell_t x, input cell_t y,
                                   input int hcells, input int vcells);
    return (int'(x) < hcells) && (int'(y) < vcells);
  endfunction

endpackage

// File: rtl/pong_frame_scheduler_if.sv
// Draw-request bus between the game-logic requesters and the frame scheduler.
interface pong_frame_scheduler_if #(
  parameter int NREQ = 2
);
  import pong_pkg::*;

  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][CELL_W-1:0]  req_x;
  logic [NREQ-1:0][CELL_W-1:0]  req_y;
  logic [NREQ-1:0][COLOR_W-1:0] req_color;

  modport master (output req_valid, req_x, req_y, req_color, input req_ready);
  modport slave  (input req_valid, req_x, req_y, req_color, output req_ready);

endinterface

// File: rtl/pong_rr_arbiter.sv
// Round-robin arbiter: the pointer holds the last granted index and the search
// starts just after it. Grants only go to valid requesters, so a grant is a transfer.
module pong_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && valid[(int'(ptr) + i) % NREQ]) begin
        grant[(int'(ptr) + i) % NREQ] = 1'b1;
        ptr_next = PW'((int'(ptr) + i) % NREQ);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(NREQ - 1);
    else     ptr <= ptr_next;
  end

endmodule

// File: rtl/pong_frame_scheduler.sv
// Double-buffered frame scheduler: clears the back buffer, accepts arbitrated
// cell draws, then swaps buffers on the next frame tick.
module pong_frame_scheduler #(
  parameter int HCELLS = pong_pkg::HCELLS,
  parameter int VCELLS = pong_pkg::VCELLS,
  parameter int NREQ   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hc,
  input  logic [9:0]            vc,
  input  pong_pkg::color_t      clear_color,
  input  logic                  draw_done,
  pong_frame_scheduler_if.slave req,
  output logic                  wr_en,
  output pong_pkg::cell_t       wr_x,
  output pong_pkg::cell_t       wr_y,
  output pong_pkg::color_t      wr_color,
  output logic                  rd_buf,
  output logic                  wr_buf,
  output logic                  frame_start,
  output logic                  frame_dropped
);
  import pong_pkg::*;

  localparam cell_t LAST_X = cell_t'(HCELLS - 1);
  localparam cell_t LAST_Y = cell_t'(VCELLS - 1);

  sched_state_t    state, state_next;
  cell_t           cx, cx_next, cy, cy_next;
  color_t          clear_lat, clear_next;
  logic            done_lat, done_next, rd_next;
  logic            wr_en_next, start_next, dropped_next;
  cell_t           wr_x_next, wr_y_next;
  color_t          wr_color_next;
  logic            tick, transfer;
  logic [NREQ-1:0] arb_valid, grant;
  cell_t           sel_x, sel_y;
  color_t          sel_color;

  assign tick      = (hc == 10'd0) && (vc == 10'd0);
  assign arb_valid = req.req_valid & {NREQ{state == ST_DRAW}};
  assign transfer  = |grant;
  assign req.req_ready = grant;

  pong_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (arb_valid),
    .grant (grant)
  );

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x     = req.req_x[i];
        sel_y     = req.req_y[i];
        sel_color = req.req_color[i];
      end
    end
  end

  always_comb begin
    state_next    = state;
    cx_next       = cx;
    cy_next       = cy;
    clear_next    = clear_lat;
    done_next     = done_lat;
    rd_next       = rd_buf;
    wr_en_next    = 1'b0;
    wr_x_next     = wr_x;
    wr_y_next     = wr_y;
    wr_color_next = wr_color;
    start_next    = 1'b0;
    dropped_next  = 1'b0;
    case (state)
      ST_CLEAR: begin
        wr_en_next    = 1'b1;
        wr_x_next     = cx;
        wr_y_next     = cy;
        wr_color_next = clear_lat;
        dropped_next  = tick;
        if (draw_done) done_next = 1'b1;
        if (cx == LAST_X) begin
          cx_next = '0;
          if (cy == LAST_Y) begin
            // A draw_done seen at any point during the sweep skips DRAW entirely
            cy_next    = '0;
            state_next = (done_lat || draw_done) ? ST_READY : ST_DRAW;
            done_next  = 1'b0;
          end else begin
            cy_next = cy + cell_t'(1);
          end
        end else begin
          cx_next = cx + cell_t'(1);
        end
      end
      ST_DRAW: begin
        dropped_next = tick;
        if (transfer) begin
          wr_en_next    = in_grid(sel_x, sel_y, HCELLS, VCELLS);
          wr_x_next     = sel_x;
          wr_y_next     = sel_y;
          wr_color_next = sel_color;
        end
        if (draw_done) state_next = ST_READY;
      end
      ST_READY: begin
        if (tick) begin
          rd_next    = ~rd_buf;
          state_next = ST_CLEAR;
          cx_next    = '0;
          cy_next    = '0;
          clear_next = clear_color;
          start_next = 1'b1;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_CLEAR;
      cx            <= '0;
      cy            <= '0;
      clear_lat     <= clear_color;
      done_lat      <= 1'b0;
      rd_buf        <= 1'b0;
      wr_buf        <= 1'b1;
      wr_en         <= 1'b0;
      wr_x          <= '0;
      wr_y          <= '0;
      wr_color      <= '0;
      frame_start   <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state         <= state_next;
      cx            <= cx_next;
      cy            <= cy_next;
      clear_lat     <= clear_next;
      done_lat      <= done_next;
      rd_buf        <= rd_next;
      wr_buf        <= ~rd_next;
      wr_en         <= wr_en_next;
      wr_x          <= wr_x_next;
      wr_y          <= wr_y_next;
      wr_color      <= wr_color_next;
      frame_start   <= start_next;
      frame_dropped <= dropped_next;
    end
  end

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Directed-vector bench for pong_frame_scheduler: clear sweeps, round-robin
// draws, buffer swaps, dropped frames and mid-sweep reset.
module tb_pong_frame_scheduler;
  import pong_pkg::*;

  logic       clk, rst, draw_done;
  logic [9:0] hc, vc;
  color_t     clear_color;
  logic       wr_en, rd_buf, wr_buf, frame_start, frame_dropped;
  cell_t      wr_x, wr_y;
  color_t     wr_color;

  int vectors     = 0;
  int miscompares = 0;

  pong_frame_scheduler_if #(.NREQ(2)) req_bus ();

  pong_frame_scheduler #(.HCELLS(32), .VCELLS(24), .NREQ(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .hc            (hc),
    .vc            (vc),
    .clear_color   (clear_color),
    .draw_done     (draw_done),
    .req           (req_bus),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_color      (wr_color),
    .rd_buf        (rd_buf),
    .wr_buf        (wr_buf),
    .frame_start   (frame_start),
    .frame_dropped (frame_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input cell_t x, input cell_t y, input color_t c);
    req_bus.req_x[idx]     = x;
    req_bus.req_y[idx]     = y;
    req_bus.req_color[idx] = c;
  endtask

  function automatic logic [31:0] wrWord(input logic en, input cell_t x, input cell_t y, input color_t c);
    return 32'({en, x, y, c});
  endfunction

  function automatic logic [31:0] wrObserved();
    return 32'({wr_en, wr_x, wr_y, wr_color});
  endfunction

  task automatic frameTick();
    hc = 10'd0;
    vc = 10'd0;
    step();
    hc = 10'd1;
    vc = 10'd0;
  endtask

  // Checks ncells consecutive clear writes; optionally injects a tick or draw_done at a cell
  task automatic runClearSweep(input color_t color, input int ncells, input int tick_at,
                               input int done_at, input logic exp_rd);
    logic [31:0] exp;
    for (int k = 0; k < ncells; k++) begin
      if (k == tick_at) begin hc = 10'd0; vc = 10'd0; end
      if (k == done_at) draw_done = 1'b1;
      step();
      hc = 10'd1;
      vc = 10'd0;
      draw_done = 1'b0;
      exp = 32'({1'b1, cell_t'(k % 32), cell_t'(k / 32), color, 1'b0, (k == tick_at), exp_rd});
      checkOutput($sformatf("clear_cell_%0d", k),
                  32'({wr_en, wr_x, wr_y, wr_color, frame_start, frame_dropped, rd_buf}), exp);
    end
  endtask

  initial begin
    logic [1:0] g;
    rst = 1'b1;
    hc = 10'd1;
    vc = 10'd0;
    draw_done = 1'b0;
    clear_color = 12'h00F;
    req_bus.req_valid = '0;
    applyStimulus(0, 5'd0, 5'd0, 12'h000);
    applyStimulus(1, 5'd0, 5'd0, 12'h000);
    step();
    step();
    checkOutput("rst_wr_en",   32'(wr_en), 32'd0);
    checkOutput("rst_rd_buf",  32'(rd_buf), 32'd0);
    checkOutput("rst_wr_buf",  32'(wr_buf), 32'd1);
    checkOutput("rst_start",   32'(frame_start), 32'd0);
    checkOutput("rst_dropped", 32'(frame_dropped), 32'd0);
    checkOutput("rst_ready",   32'(req_bus.req_ready), 32'd0);
    rst = 1'b0;

    runClearSweep(12'h00F, 768, -1, -1, 1'b0);

    applyStimulus(0, 5'd1, 5'd2, 12'h111);
    applyStimulus(1, 5'd3, 5'd4, 12'h222);
    req_bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("rr_grant_%0d", k), 32'(req_bus.req_ready), 32'(g));
      step();
      if (k % 2 == 0) checkOutput($sformatf("rr_write_%0d", k), wrObserved(), wrWord(1'b1, 5'd1, 5'd2, 12'h111));
      else            checkOutput($sformatf("rr_write_%0d", k), wrObserved(), wrWord(1'b1, 5'd3, 5'd4, 12'h222));
    end
    req_bus.req_valid = 2'b00;
    step();
    checkOutput("idle_no_write", 32'(wr_en), 32'd0);

    applyStimulus(0, 5'd31, 5'd24, 12'h999);
    req_bus.req_valid = 2'b01;
    #1;
    checkOutput("oor_ready", 32'(req_bus.req_ready), 32'b01);
    step();
    checkOutput("oor_no_write", 32'(wr_en), 32'd0);
    req_bus.req_valid = 2'b11;
    #1;
    checkOutput("rr_after_oor", 32'(req_bus.req_ready), 32'b10);
    req_bus.req_valid = 2'b00;

    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    req_bus.req_valid = 2'b01;
    #1;
    checkOutput("no_ready_in_ready", 32'(req_bus.req_ready), 32'd0);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    req_bus.req_valid = 2'b00;
    checkOutput("ready_no_write", 32'(wr_en), 32'd0);
    checkOutput("ready_rd_hold", 32'(rd_buf), 32'd0);

    clear_color = 12'h0F0;
    frameTick();
    clear_color = 12'hABC;
    checkOutput("swap1_start", 32'(frame_start), 32'd1);
    checkOutput("swap1_rd",    32'(rd_buf), 32'd1);
    checkOutput("swap1_wr",    32'(wr_buf), 32'd0);
    checkOutput("swap1_wr_en", 32'(wr_en), 32'd0);

    runClearSweep(12'h0F0, 768, 100, 500, 1'b1);

    req_bus.req_valid = 2'b01;
    #1;
    checkOutput("early_done_ready", 32'(req_bus.req_ready), 32'd0);
    step();
    checkOutput("early_done_no_write", 32'(wr_en), 32'd0);
    req_bus.req_valid = 2'b00;
    clear_color = 12'hF00;
    frameTick();
    checkOutput("swap2_start", 32'(frame_start), 32'd1);
    checkOutput("swap2_rd",    32'(rd_buf), 32'd0);
    checkOutput("swap2_wr",    32'(wr_buf), 32'd1);

    runClearSweep(12'hF00, 768, -1, -1, 1'b0);

    applyStimulus(1, 5'd5, 5'd6, 12'h333);
    req_bus.req_valid = 2'b10;
    #1;
    checkOutput("single_req1_ready", 32'(req_bus.req_ready), 32'b10);
    step();
    checkOutput("single_req1_write", wrObserved(), wrWord(1'b1, 5'd5, 5'd6, 12'h333));
    req_bus.req_valid = 2'b00;

    frameTick();
    checkOutput("draw_tick_dropped", 32'(frame_dropped), 32'd1);
    checkOutput("draw_tick_rd",      32'(rd_buf), 32'd0);
    checkOutput("draw_tick_start",   32'(frame_start), 32'd0);
    req_bus.req_valid = 2'b01;
    #1;
    checkOutput("still_draw_ready", 32'(req_bus.req_ready), 32'b01);
    req_bus.req_valid = 2'b00;

    draw_done = 1'b1;
    frameTick();
    draw_done = 1'b0;
    checkOutput("tick_done_dropped", 32'(frame_dropped), 32'd1);
    checkOutput("tick_done_rd",      32'(rd_buf), 32'd0);
    req_bus.req_valid = 2'b01;
    #1;
    checkOutput("tick_done_ready_state", 32'(req_bus.req_ready), 32'd0);
    req_bus.req_valid = 2'b00;
    clear_color = 12'h777;
    frameTick();
    checkOutput("swap3_start", 32'(frame_start), 32'd1);
    checkOutput("swap3_rd",    32'(rd_buf), 32'd1);

    runClearSweep(12'h777, 400, -1, -1, 1'b1);
    clear_color = 12'h0AA;
    rst = 1'b1;
    step();
    checkOutput("midrst_wr_en",   32'(wr_en), 32'd0);
    checkOutput("midrst_rd_buf",  32'(rd_buf), 32'd0);
    checkOutput("midrst_wr_buf",  32'(wr_buf), 32'd1);
    checkOutput("midrst_start",   32'(frame_start), 32'd0);
    checkOutput("midrst_dropped", 32'(frame_dropped), 32'd0);
    rst = 1'b0;

    runClearSweep(12'h0AA, 768, -1, -1, 1'b0);

    applyStimulus(0, 5'd7, 5'd8, 12'h444);
    req_bus.req_valid = 2'b11;
    #1;
    checkOutput("rr_after_reset", 32'(req_bus.req_ready), 32'b01);
    step();
    checkOutput("rr_after_reset_write", wrObserved(), wrWord(1'b1, 5'd7, 5'd8, 12'h444));
    req_bus.req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
